// File: rtl/handshake_stage_combine.sv
// Four-phase req/ack pipeline stage with a small FIFO buffer.
// Unit cell for chaining into handshake FIFOs.
module handshake_stage_combine #(
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_in,
  output logic                  ack_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  req_out,
  input  logic                  ack_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    IN_IDLE,
    IN_ACK
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_REQ,
    OUT_RTZ
  } out_state_t;

  in_state_t  in_state, in_next;
  out_state_t out_state, out_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic push;
  logic pop;
  logic load;
  logic full;

  // Full is judged on the registered count: no same-edge bypass.
  assign full    = (count == FULL_CNT);
  assign ack_out = (in_state == IN_ACK);
  assign req_out = (out_state == OUT_REQ);

  // Next-state and strobe decode for both handshake FSMs.
  always_comb begin
    in_next  = in_state;
    out_next = out_state;
    push     = 1'b0;
    pop      = 1'b0;
    load     = 1'b0;

    unique case (in_state)
      IN_IDLE: begin
        if (req_in && !full) begin
          push    = 1'b1;
          in_next = IN_ACK;
        end
      end
      IN_ACK: begin
        if (!req_in) begin
          in_next = IN_IDLE;
        end
      end
      default: in_next = IN_IDLE;
    endcase

    unique case (out_state)
      OUT_IDLE: begin
        if (count != '0) begin
          load     = 1'b1;
          out_next = OUT_REQ;
        end
      end
      OUT_REQ: begin
        if (ack_in) begin
          pop      = 1'b1;
          out_next = OUT_RTZ;
        end
      end
      OUT_RTZ: begin
        if (!ack_in) begin
          out_next = OUT_IDLE;
        end
      end
      default: out_next = OUT_IDLE;
    endcase
  end

  // State, pointers, occupancy and the presented word.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_state  <= IN_IDLE;
      out_state <= OUT_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (load) begin
        data_out <= mem[rd_ptr];
      end
    end
  end

  // Buffer storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

endmodule

// File: tb/tb_handshake_stage_combine.sv
// Directed bench for handshake_stage_combine.
// Each task drives one scenario and checks inline.
module tb_handshake_stage_combine;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_in;
  logic       ack_out;
  logic [2:0] data_in;
  logic       req_out;
  logic       ack_in;
  logic [2:0] data_out;

  int tests_run    = 0;
  int tests_failed = 0;

  handshake_stage_combine #(
    .DATA_WIDTH(3),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_in(req_in),
    .ack_out(ack_out),
    .data_in(data_in),
    .req_out(req_out),
    .ack_in(ack_in),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_in = 1'b0; ack_in = 1'b0; data_in = 3'd0;
    step();
    step();
    tests_run++;
    if ({ack_out, req_out, data_out} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_hold got ack=%b req=%b data=%0d want 0/0/0",
               ack_out, req_out, data_out);
    end
    rst = 1'b0;
    step();
    step();
    tests_run++;
    if ({ack_out, req_out, data_out} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_release got ack=%b req=%b data=%0d want 0/0/0",
               ack_out, req_out, data_out);
    end
  endtask

  task automatic test_single();
    req_in = 1'b1; data_in = 3'd1;
    step();
    tests_run++;
    if (ack_out !== 1'b1 || req_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_ack got ack=%b req=%b want 1/0", ack_out, req_out);
    end
    step();
    tests_run++;
    if (req_out !== 1'b1 || data_out !== 3'd1) begin
      tests_failed++;
      $display("FAIL single_req got req=%b data=%0d want 1/1", req_out, data_out);
    end
    req_in = 1'b0;
    step();
    tests_run++;
    if (ack_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_ack_drop got %b want 0", ack_out);
    end
    ack_in = 1'b1;
    step();
    tests_run++;
    if (req_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_req_drop got %b want 0", req_out);
    end
    ack_in = 1'b0;
    step();
    step();
    tests_run++;
    if (req_out !== 1'b0 || ack_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_idle got req=%b ack=%b want 0/0", req_out, ack_out);
    end
  endtask

  task automatic send_word(input logic [2:0] d, input string name);
    req_in = 1'b1; data_in = d;
    step();
    tests_run++;
    if (ack_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_ack got %b want 1", name, ack_out);
    end
    req_in = 1'b0;
    step();
    tests_run++;
    if (ack_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_rtz got %b want 0", name, ack_out);
    end
  endtask

  task automatic test_fill_stall();
    send_word(3'd1, "fill_w1");
    send_word(3'd2, "fill_w2");
    req_in = 1'b1; data_in = 3'd3;
    step();
    step();
    tests_run++;
    if (ack_out !== 1'b0 || req_out !== 1'b1 || data_out !== 3'd1) begin
      tests_failed++;
      $display("FAIL fill_stall got ack=%b req=%b data=%0d want 0/1/1",
               ack_out, req_out, data_out);
    end
    ack_in = 1'b1;
    step();
    tests_run++;
    if (ack_out !== 1'b0 || req_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_pop_edge got ack=%b req=%b want 0/0", ack_out, req_out);
    end
    step();
    tests_run++;
    if (ack_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_w3_ack got %b want 1", ack_out);
    end
    ack_in = 1'b0; req_in = 1'b0;
    step();
    step();
    tests_run++;
    if (req_out !== 1'b1 || data_out !== 3'd2) begin
      tests_failed++;
      $display("FAIL fill_head2 got req=%b data=%0d want 1/2", req_out, data_out);
    end
    ack_in = 1'b1; step();
    ack_in = 1'b0; step();
    step();
    tests_run++;
    if (req_out !== 1'b1 || data_out !== 3'd3) begin
      tests_failed++;
      $display("FAIL fill_head3 got req=%b data=%0d want 1/3", req_out, data_out);
    end
    ack_in = 1'b1; step();
    ack_in = 1'b0; step();
    step();
    tests_run++;
    if (req_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_empty got req=%b want 0", req_out);
    end
  endtask

  task automatic test_order_wrap();
    logic [2:0] exp [5];
    int budget;
    exp[0] = 3'd1; exp[1] = 3'd2; exp[2] = 3'd3;
    exp[3] = 3'd4; exp[4] = 3'd5;
    for (int i = 0; i < 5; i++) begin
      send_word(exp[i], "order");
      budget = 0;
      while (req_out !== 1'b1 && budget < 10) begin
        step();
        budget++;
      end
      tests_run++;
      if (req_out !== 1'b1 || data_out !== exp[i]) begin
        tests_failed++;
        $display("FAIL order_%0d got req=%b data=%0d want 1/%0d",
                 i, req_out, data_out, exp[i]);
      end
      ack_in = 1'b1; step();
      ack_in = 1'b0; step();
    end
  endtask

  task automatic test_back_to_back();
    send_word(3'd2, "b2b_w2");
    tests_run++;
    if (req_out !== 1'b1 || data_out !== 3'd2) begin
      tests_failed++;
      $display("FAIL b2b_head got req=%b data=%0d want 1/2", req_out, data_out);
    end
    req_in = 1'b1; data_in = 3'd3; ack_in = 1'b1;
    step();
    tests_run++;
    if (ack_out !== 1'b1 || req_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_edge got ack=%b req=%b want 1/0", ack_out, req_out);
    end
    req_in = 1'b0; ack_in = 1'b0;
    step();
    step();
    tests_run++;
    if (req_out !== 1'b1 || data_out !== 3'd3) begin
      tests_failed++;
      $display("FAIL b2b_next got req=%b data=%0d want 1/3", req_out, data_out);
    end
    ack_in = 1'b1; step();
    ack_in = 1'b0; step();
    step();
    step();
    tests_run++;
    if (req_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_count got req=%b want 0", req_out);
    end
  endtask

  task automatic test_reset_mid();
    req_in = 1'b1; data_in = 3'd5;
    step();
    step();
    tests_run++;
    if (ack_out !== 1'b1 || req_out !== 1'b1 || data_out !== 3'd5) begin
      tests_failed++;
      $display("FAIL mid_setup got ack=%b req=%b data=%0d want 1/1/5",
               ack_out, req_out, data_out);
    end
    rst = 1'b1; req_in = 1'b0;
    step();
    tests_run++;
    if ({ack_out, req_out, data_out} !== 5'b0) begin
      tests_failed++;
      $display("FAIL mid_reset got ack=%b req=%b data=%0d want 0/0/0",
               ack_out, req_out, data_out);
    end
    rst = 1'b0;
    step();
    step();
    step();
    tests_run++;
    if ({ack_out, req_out, data_out} !== 5'b0) begin
      tests_failed++;
      $display("FAIL mid_after got ack=%b req=%b data=%0d want 0/0/0",
               ack_out, req_out, data_out);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_order_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/handshake_stage_combine.md
Name: handshake_stage_combine

Overview:
- Clocked four-phase (return-to-zero) request/acknowledge pipeline stage with a small internal FIFO buffer.
- Input side: upstream drives req_in/data_in, the stage answers with ack_out.
- Output side: the stage drives req_out/data_out, downstream answers with ack_in.
- Used as the unit cell chained to build handshake FIFOs.

Parameters:
- DATA_WIDTH, 3, width of data_in/data_out.
- DEPTH, 2, buffer entries; power of two, >= 2.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset, synchronous and active-high.
- req_in  input  1  upstream request; data_in valid while high.
- ack_out  output  1  acknowledge to upstream.
- data_in  input  DATA_WIDTH  upstream data.
- req_out  output  1  request to downstream.
- ack_in  input  1  acknowledge from downstream.
- data_out  output  DATA_WIDTH  data to downstream; registered.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - ack_out=0, req_out=0, data_out=0.
  - Buffer count=0, read/write pointers=0.
  - Both FSMs go to idle.
  - Reset overrides everything, including mid-handshake; any in-flight word is discarded.
- Input FSM:
  - IN_IDLE: if req_in=1 and count<DEPTH at an edge, write data_in at wr_ptr, increment wr_ptr (wraps mod DEPTH), set ack_out=1, go to IN_ACK.
  - IN_IDLE with buffer full: hold ack_out=0 and do not write.
  - IN_ACK: hold ack_out=1. When req_in=0 at an edge, clear ack_out and return to IN_IDLE.
  - Exactly one word is accepted per req_in high phase.
- Output FSM:
  - OUT_IDLE: if count>0 at an edge, load data_out from the head entry, set req_out=1, go to OUT_REQ.
  - OUT_REQ: req_out and data_out are held stable. When ack_in=1 at an edge, clear req_out, pop the head (rd_ptr+1 mod DEPTH, count-1), go to OUT_RTZ.
  - OUT_RTZ: when ack_in=0 at an edge, go to OUT_IDLE.
  - An ack_in=1 seen in OUT_IDLE is ignored.
- Latency:
  - ack_out rises on the edge that samples req_in=1 with space available.
  - For an empty stage, req_out rises one edge after the write edge.
  - Minimum time from the write edge to req_out rising: 1 cycle.
- Simultaneous events:
  - A push and a pop on the same edge are both performed; count is unchanged.
  - A push is permitted on the edge a pop frees a slot only if count<DEPTH before that edge. No combinational full bypass.
- Order: strict FIFO. Pointer wrap at DEPTH is transparent to the handshakes.
- data_out changes only on the OUT_IDLE to OUT_REQ transition (or on reset).

Test Plan:
- Reset: hold rst=1 for 2 edges -> ack_out=0, req_out=0, data_out=0. Then release with all inputs 0 -> outputs stay 0.
- Single transfer:
  - req_in=1, data_in=1 -> ack_out=1 after that edge; req_out=1 with data_out=1 one edge later.
  - Drop req_in -> ack_out=0 next edge.
  - Raise ack_in -> req_out=0 next edge.
  - Drop ack_in -> stage idle and empty.
- Fill and stall: keep ack_in=0; send 1, 2, then 3 with full handshakes -> 1 and 2 are acked. Word 3 is not acked (ack_out stays 0) until downstream completes the ack for word 1; then 3 is acked.
- Ordering/wrap: stream 1,2,3,4,5 with interleaved downstream handshakes -> data_out sequence is exactly 1,2,3,4,5.
- Simultaneous push/pop: count=1 (head=2). On one edge, req_in=1 (data 3) in IN_IDLE and ack_in=1 in OUT_REQ -> word 3 accepted, word 2 popped, count stays 1, next req_out carries 3.
- Reset mid-handshake: rst=1 while ack_out=1 and req_out=1 -> both 0 on the next edge, data_out=0, buffer empty; the held word is not presented afterwards.
